axi_exit_ctrl: RTL and testbench

Parametrised AXI4-Lite slave that signals end of a simulation or FPGA test run. Software writes an exit code or a pass marker; the block latches the result and drives `exit_valid_o`, `exit_zero_o` and a 32-bit `exit_value_o` to the testbench or board-level monitor. It also provides a status register and a bank of read/write scratch registers. It implements the AXI4-Lite handshakes natively, with no external AXI-to-BRAM bridge, and sits on the SoC peripheral interconnect.

---
 rtl/axi_exit_ctrl.sv | 179 +++++++++++++++++
 tb/tb_axi_exit_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_exit_ctrl.sv
// rtl/axi_exit_ctrl.sv - AXI4-Lite slave that latches a test-run exit code, plus status and scratch registers
module axi_exit_ctrl #(
    parameter int ADDR_WIDTH  = 20,
    parameter int NUM_SCRATCH = 4,
    parameter int STICKY_EXIT = 1
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        exit_valid_o,
    output logic        exit_zero_o,
    output logic [31:0] exit_value_o
);
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] W_STATUS = WW'(0);
    localparam logic [WW-1:0] W_CODE   = WW'(1);
    localparam logic [WW-1:0] W_PASS   = WW'(4);
    localparam logic [WW-1:0] W_SCR    = WW'(8);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    logic        ready_en;
    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [7:0]  exit_cnt;
    logic [31:0] scratch [NUM_SCRATCH];

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] cm_addr, cm_data, cm_mask, exit_val;
    logic [3:0]  cm_strb;
    logic [WW-1:0] wr_word, rd_word;
    logic        wr_code, wr_pass, wr_ok, is_exit;
    logic [NUM_SCRATCH-1:0] wr_scr;
    logic [31:0] rd_data, status;
    logic        rd_ok;
    logic        unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    // Ready is held low through reset and for the release edge itself.
    assign s_axi_awready = ready_en && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = ready_en && !w_held && !s_axi_bvalid;
    assign s_axi_arready = ready_en && !s_axi_rvalid;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !s_axi_bvalid;
    assign cm_addr = aw_held ? aw_addr_q : s_axi_awaddr;
    assign cm_data = w_held ? w_data_q : s_axi_wdata;
    assign cm_strb = w_held ? w_strb_q : s_axi_wstrb;
    assign cm_mask = {{8{cm_strb[3]}}, {8{cm_strb[2]}}, {8{cm_strb[1]}}, {8{cm_strb[0]}}};
    assign wr_word = cm_addr[ADDR_WIDTH-1:2];
    assign rd_word = s_axi_araddr[ADDR_WIDTH-1:2];
    assign wr_code = (wr_word == W_CODE);
    assign wr_pass = (wr_word == W_PASS);
    assign is_exit = (wr_code || wr_pass) && (cm_strb != 4'h0);
    assign exit_val = wr_pass ? 32'h0 : (cm_data & cm_mask);
    assign status  = {16'h0, exit_cnt, 6'h0, exit_zero_o, exit_valid_o};

    always_comb begin
        wr_scr = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            wr_scr[i] = (wr_word == W_SCR + WW'(i));
        end
        wr_ok = (wr_word == W_STATUS) || wr_code || wr_pass || (wr_scr != '0);
    end

    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b1;
        if (rd_word == W_STATUS) begin
            rd_data = status;
        end else if (rd_word == W_CODE) begin
            rd_data = exit_value_o;
        end else if (rd_word != W_PASS) begin
            rd_ok = 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (rd_word == W_SCR + WW'(i)) begin
                    rd_data = scratch[i];
                    rd_ok   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            ready_en     <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
            exit_valid_o <= 1'b0;
            exit_zero_o  <= 1'b0;
            exit_value_o <= '0;
            exit_cnt     <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi_wdata;
                    w_strb_q <= s_axi_wstrb;
                end
            end

            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (commit && is_exit) begin
                if (exit_cnt != 8'hFF) begin
                    exit_cnt <= exit_cnt + 8'd1;
                end
                if (!((STICKY_EXIT != 0) && exit_valid_o)) begin
                    exit_valid_o <= 1'b1;
                    exit_value_o <= exit_val;
                    exit_zero_o  <= (exit_val == 32'h0);
                end
            end

            for (int i = 0; i < NUM_SCRATCH; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (commit && wr_scr[i] && cm_strb[b]) begin
                        scratch[i][8*b +: 8] <= cm_data[8*b +: 8];
                    end
                end
            end

            // Read data is captured from pre-commit state, so a same-cycle write is not visible.
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_exit_ctrl.sv
// tb/tb_axi_exit_ctrl.sv - directed self-checking bench for axi_exit_ctrl
module tb_axi_exit_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ex_valid, ex_zero;
    logic [31:0] ex_value;
    logic        n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
    logic [1:0]  n_bresp, n_rresp;
    logic [31:0] n_rdata;
    logic        n_valid, n_zero;
    logic [31:0] n_value;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_exit_ctrl dut (
        .s_axi_aclk(clk), .s_axi_aresetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .exit_valid_o(ex_valid), .exit_zero_o(ex_zero), .exit_value_o(ex_value)
    );

    axi_exit_ctrl #(.STICKY_EXIT(0)) dut_ns (
        .s_axi_aclk(clk), .s_axi_aresetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(n_awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(n_wready),
        .s_axi_bresp(n_bresp), .s_axi_bvalid(n_bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(n_arready),
        .s_axi_rdata(n_rdata), .s_axi_rresp(n_rresp), .s_axi_rvalid(n_rvalid), .s_axi_rready(rready),
        .exit_valid_o(n_valid), .exit_zero_o(n_zero), .exit_value_o(n_value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the B handshake.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic b_now);
        logic hs_aw, hs_w;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 50 && (awvalid || wvalid); n++) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(negedge clk);
            if (hs_aw) awvalid = 1'b0;
            if (hs_w) wvalid = 1'b0;
        end
        if (awvalid || wvalid) chk("wr_addr_timeout", 32'd1, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        b_now = bvalid;
        for (int n = 0; n < 50 && !bvalid; n++) @(negedge clk);
        if (!bvalid) chk("wr_resp_timeout", 32'd1, 32'd0);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic hs;
        araddr = a;
        arvalid = 1'b1;
        for (int n = 0; n < 50 && arvalid; n++) begin
            hs = arready;
            @(negedge clk);
            if (hs) arvalid = 1'b0;
        end
        if (arvalid || !rvalid) chk("rd_timeout", 32'd1, 32'd0);
        arvalid = 1'b0;
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic        b_now;
    logic [31:0] rd;

    initial begin
        resetn = 1'b0; awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0;
        wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_exit", {29'd0, ex_valid, ex_zero, |ex_value}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {29'd0, awready, wready, arready}, 32'h7);

        axi_wr(32'h04, 32'h0000_002A, 4'hF, resp, b_now);
        chk("code_b_latency", {31'd0, b_now}, 32'd1);
        chk("code_bresp", {30'd0, resp}, 32'd0);
        chk("code_exit_flags", {30'd0, ex_valid, ex_zero}, 32'h2);
        chk("code_exit_value", ex_value, 32'h2A);
        axi_rd(32'h00, rd, resp);
        chk("status_1", rd, 32'h0000_0101);

        do_reset();
        axi_wr(32'h10, 32'hFFFF_FFFF, 4'hF, resp, b_now);
        chk("pass_flags", {30'd0, ex_valid, ex_zero}, 32'h3);
        chk("pass_value", ex_value, 32'h0);
        axi_wr(32'h04, 32'h7, 4'hF, resp, b_now);
        chk("sticky_value", ex_value, 32'h0);
        chk("sticky_zero", {31'd0, ex_zero}, 32'd1);
        chk("nonsticky_value", n_value, 32'h7);
        chk("nonsticky_zero", {31'd0, n_zero}, 32'd0);
        axi_rd(32'h00, rd, resp);
        chk("status_2", rd, 32'h0000_0203);

        axi_wr(32'h04, 32'h1234_5678, 4'h0, resp, b_now);
        chk("strb0_bresp", {30'd0, resp}, 32'd0);
        chk("strb0_ns_value", n_value, 32'h7);
        axi_rd(32'h00, rd, resp);
        chk("strb0_status", rd, 32'h0000_0203);
        axi_wr(32'h04, 32'hAABB_CCDD, 4'h2, resp, b_now);
        chk("strb2_ns_value", n_value, 32'h0000_CC00);
        chk("strb2_sticky_value", ex_value, 32'h0);
        axi_rd(32'h00, rd, resp);
        chk("status_3", rd, 32'h0000_0303);
        axi_rd(32'h10, rd, resp);
        chk("pass_rd", {rd[31:2], resp}, 32'h0);
        axi_wr(32'h00, 32'hFFFF_FFFF, 4'hF, resp, b_now);
        chk("status_wr_bresp", {30'd0, resp}, 32'd0);
        axi_rd(32'h00, rd, resp);
        chk("status_after_wr", rd, 32'h0000_0303);

        // W leads AW by three cycles, B held off for five.
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("early_w_ready", {30'd0, wready, bvalid}, 32'd0);
        awaddr = 32'h20; awvalid = 1'b1;
        chk("early_aw_ready", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("early_bvalid", {31'd0, bvalid}, 32'd1);
        for (int n = 0; n < 5; n++) begin
            chk("bhold_state", {29'd0, awready, wready, bvalid}, 32'h1);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("after_b", {30'd0, awready, bvalid}, 32'h2);
        axi_rd(32'h20, rd, resp);
        chk("scratch0", rd, 32'hDEAD_BEEF);

        axi_wr(32'h24, 32'h1234_5678, 4'hF, resp, b_now);
        axi_wr(32'h24, 32'hFF00_0000, 4'h8, resp, b_now);
        axi_rd(32'h27, rd, resp);
        chk("scratch1_byte", rd, 32'hFF34_5678);
        axi_rd(32'h0010_0024, rd, resp);
        chk("scratch1_hi_alias", rd, 32'hFF34_5678);

        axi_wr(32'h100, 32'h1, 4'hF, resp, b_now);
        chk("unmapped_bresp", {30'd0, resp}, 32'h2);
        axi_rd(32'h100, rd, resp);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_rresp", {30'd0, resp}, 32'h2);
        axi_wr(32'h30, 32'h1, 4'hF, resp, b_now);
        chk("scr_end_bresp", {30'd0, resp}, 32'h2);
        axi_rd(32'h30, rd, resp);
        chk("scr_end_rresp", {30'd0, resp}, 32'h2);

        // Reset while a read response is still pending.
        araddr = 32'h24; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("pend_rvalid", {31'd0, rvalid}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_exit", {29'd0, ex_valid, ex_zero, |ex_value}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        axi_rd(32'h24, rd, resp);
        chk("midrst_scratch", rd, 32'h0);
        axi_wr(32'h04, 32'h5, 4'hF, resp, b_now);
        chk("post_rst_bresp", {30'd0, resp}, 32'd0);
        chk("post_rst_value", ex_value, 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
